cache_lru_arbiter: RTL and testbench
====================================

CACHE_LRU_ARBITER -- requirements
Module: cache_lru_arbiter

Interface
REQ-001 SHALL have parameter SET_BITS, default 9, giving the LRU set-address width (number of sets = 2^SET_BITS).
REQ-002 SHALL have parameter INIT_ON_RESET, default 1: 1 = run INIT sweep after reset, 0 = enter RUN directly.
REQ-003 main_clk  in  1  sole clock, all state on rising edge.
REQ-004 main_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N has an access pending.
REQ-006 reqN_ready  out  1  access of requester N accepted this cycle when high with reqN_valid.
REQ-007 reqN_addr  in  SET_BITS  set index of requester N.
REQ-008 reqN_touch  in  1  1 = update LRU with reqN_used_index; 0 = victim lookup only.
REQ-009 reqN_used_index  in  2  way just used by requester N.
REQ-010 rspN_valid  out  1  one-cycle pulse, victim for requester N available.
REQ-011 rspN_victim  out  2  least-recently-used way of the set, pre-update.
REQ-012 flush_req  in  1  pulse; restart INIT sweep.
REQ-013 busy  out  1  high while in INIT.
REQ-014 lru_addr  out  SET_BITS  set address to the LRU store.
REQ-015 lru_used_index  out  2  way index to the LRU store.
REQ-016 lru_enable_write  out  1  LRU update strobe, same cycle as lru_addr.
REQ-017 lru_least_used_index  in  2  LRU store result, valid 2 cycles after its lru_addr cycle.

Function
REQ-018 SHALL implement states INIT and RUN: INIT->RUN after last sweep write; RUN->INIT on the cycle after flush_req sampled high in RUN; flush_req ignored in INIT.
REQ-019 INIT SHALL drive, per set s = 0..2^SET_BITS-1 ascending, four consecutive cycles of lru_addr=s, lru_enable_write=1, lru_used_index = 3,2,1,0; total 4*2^SET_BITS cycles (2048 at default).
REQ-020 After INIT, every set SHALL report least-used way 3.
REQ-021 In INIT, req0_ready and req1_ready SHALL be 0 and busy SHALL be 1.
REQ-022 In RUN, at most one requester SHALL be granted per cycle; reqN_ready = RUN && grant==N, combinational from reqN_valid and the priority pointer.
REQ-023 Arbitration SHALL be round-robin: single valid requester wins; both valid -> pointer owner wins; pointer moves to the other port after every grant made while both valid.
REQ-024 On acceptance in cycle t, lru_addr/lru_used_index SHALL equal the winner's addr/used_index and lru_enable_write = winner's touch, all in cycle t, combinational.
REQ-025 With no grant and not INIT, lru_enable_write SHALL be 0; lru_addr and lru_used_index SHALL be 0.
REQ-026 rspN_valid SHALL pulse in cycle t+2 for an acceptance of requester N in cycle t, with rspN_victim = lru_least_used_index in that cycle; routing via a 2-stage {valid,port} shift register.
REQ-027 Back-to-back accesses, one per cycle, from either port, including the same set, SHALL be supported without stall; same-set ordering is handled by the LRU store's read-through.
REQ-028 Responses SHALL have no backpressure; requester must accept rspN_valid.
REQ-029 Accesses accepted before flush SHALL still deliver responses in t+2 during INIT.
REQ-030 rspN_victim SHALL hold its last value when rspN_valid is 0.
REQ-031 INIT sweep writes SHALL NOT produce responses.

Reset
REQ-032 On main_rst_n low, asynchronously: state = INIT (RUN if INIT_ON_RESET=0), sweep counters 0, pointer = port 0, response pipe cleared, rsp0_valid = rsp1_valid = 0, rsp victims 0, busy = INIT_ON_RESET.
REQ-033 Reset mid-operation SHALL discard in-flight responses; no rspN_valid pulse after deassertion for pre-reset accesses.
REQ-034 After deassertion, the sweep SHALL start at set 0, used_index 3, on the first clock edge.

Verification
REQ-035 Reset release -> busy high exactly 2048 cycles, lru_addr walks 0..511 with used_index 3,2,1,0 per set; then req0 lookup of set 5 -> rsp0_victim = 3 at t+2.
REQ-036 Both ports valid every cycle, set 7 and 9 -> grants alternate 0,1,0,1; each rsp pulses exactly t+2 on the correct port.
REQ-037 Port 0 touches set 4 with ways 3,0,1 on consecutive cycles, then lookup -> victims 3,2,2 then 2.
REQ-038 flush_req in RUN with accesses in flight -> in-flight responses delivered, ready low next cycle, full 2048-cycle sweep, all sets report victim 3 after.
REQ-039 main_rst_n asserted one cycle after an acceptance -> no rspN_valid for it; sweep restarts at set 0.

Source files
------------

// File: rtl/cache_lru_arbiter_if.sv
// Bundle of requester, response and LRU-store signals around the cache LRU arbiter.
// slave is the arbiter's view, master is the view of the requesters plus LRU store.
interface cache_lru_arbiter_if #(
   parameter int unsigned SET_BITS = 9
) ();
   logic                req0_valid;
   logic                req0_ready;
   logic [SET_BITS-1:0] req0_addr;
   logic                req0_touch;
   logic [1:0]          req0_used_index;
   logic                req1_valid;
   logic                req1_ready;
   logic [SET_BITS-1:0] req1_addr;
   logic                req1_touch;
   logic [1:0]          req1_used_index;
   logic                rsp0_valid;
   logic [1:0]          rsp0_victim;
   logic                rsp1_valid;
   logic [1:0]          rsp1_victim;
   logic                flush_req;
   logic                busy;
   logic [SET_BITS-1:0] lru_addr;
   logic [1:0]          lru_used_index;
   logic                lru_enable_write;
   logic [1:0]          lru_least_used_index;

   modport slave (
      input  req0_valid, req0_addr, req0_touch, req0_used_index,
      input  req1_valid, req1_addr, req1_touch, req1_used_index,
      input  flush_req, lru_least_used_index,
      output req0_ready, req1_ready, rsp0_valid, rsp0_victim, rsp1_valid, rsp1_victim,
      output busy, lru_addr, lru_used_index, lru_enable_write
   );

   modport master (
      output req0_valid, req0_addr, req0_touch, req0_used_index,
      output req1_valid, req1_addr, req1_touch, req1_used_index,
      output flush_req, lru_least_used_index,
      input  req0_ready, req1_ready, rsp0_valid, rsp0_victim, rsp1_valid, rsp1_victim,
      input  busy, lru_addr, lru_used_index, lru_enable_write
   );
endinterface

// File: rtl/cache_lru_arbiter.sv
// Two-port round-robin arbiter in front of a pseudo-LRU store with a 2-cycle read latency.
// Runs an init sweep (after reset or flush) that leaves way 3 as the victim of every set.
module cache_lru_arbiter #(
   parameter int unsigned SET_BITS      = 9,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input logic                main_clk,
   input logic                main_rst_n,
   cache_lru_arbiter_if.slave bus
);

   typedef enum logic {StInit, StRun} state_e;

   localparam state_e              ResetState = INIT_ON_RESET ? StInit : StRun;
   localparam logic [SET_BITS-1:0] SetOne     = {{(SET_BITS-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [SET_BITS-1:0] sweep_set_q, sweep_set_d;
   logic [1:0]          sweep_way_q, sweep_way_d;
   logic                ptr_q, ptr_d;
   logic                run, grant0, grant1;
   logic                p1_valid_q, p1_port_q, p2_valid_q, p2_port_q;
   logic                rsp0_hit, rsp1_hit;
   logic [1:0]          victim0_q, victim1_q;

   // Grant decision: single requester wins, contention goes to the pointer owner.
   always_comb begin
      run            = (state_q == StRun);
      grant0         = run && bus.req0_valid && (!bus.req1_valid || !ptr_q);
      grant1         = run && bus.req1_valid && (!bus.req0_valid || ptr_q);
      bus.req0_ready = grant0;
      bus.req1_ready = grant1;
      bus.busy       = !run;
   end

   // Drive the LRU store from the sweep counters in INIT, else from the winner.
   always_comb begin
      bus.lru_addr         = '0;
      bus.lru_used_index   = 2'd0;
      bus.lru_enable_write = 1'b0;
      if (state_q == StInit) begin
         bus.lru_addr         = sweep_set_q;
         bus.lru_used_index   = ~sweep_way_q; // 3,2,1,0 leaves way 3 least recent
         bus.lru_enable_write = 1'b1;
      end else if (grant0) begin
         bus.lru_addr         = bus.req0_addr;
         bus.lru_used_index   = bus.req0_used_index;
         bus.lru_enable_write = bus.req0_touch;
      end else if (grant1) begin
         bus.lru_addr         = bus.req1_addr;
         bus.lru_used_index   = bus.req1_used_index;
         bus.lru_enable_write = bus.req1_touch;
      end
   end

   // Next state, sweep counters and round-robin pointer.
   always_comb begin
      state_d     = state_q;
      sweep_set_d = sweep_set_q;
      sweep_way_d = sweep_way_q;
      ptr_d       = (run && bus.req0_valid && bus.req1_valid) ? ~ptr_q : ptr_q;
      unique case (state_q)
         StInit: begin
            sweep_way_d = sweep_way_q + 2'd1;
            if (sweep_way_q == 2'd3) begin
               sweep_set_d = sweep_set_q + SetOne;
               if (sweep_set_q == '1) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (bus.flush_req) begin
               state_d     = StInit;
               sweep_set_d = '0;
               sweep_way_d = 2'd0;
            end
         end
         default: state_d = state_q;
      endcase
   end

   // Control state register.
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         state_q     <= ResetState;
         sweep_set_q <= '0;
         sweep_way_q <= 2'd0;
         ptr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_set_q <= sweep_set_d;
         sweep_way_q <= sweep_way_d;
         ptr_q       <= ptr_d;
      end
   end

   // Route the store result back to the port whose access is two cycles old.
   always_comb begin
      rsp0_hit        = p2_valid_q && !p2_port_q;
      rsp1_hit        = p2_valid_q && p2_port_q;
      bus.rsp0_valid  = rsp0_hit;
      bus.rsp1_valid  = rsp1_hit;
      bus.rsp0_victim = rsp0_hit ? bus.lru_least_used_index : victim0_q;
      bus.rsp1_victim = rsp1_hit ? bus.lru_least_used_index : victim1_q;
   end

   // Response pipe and held victims; flush leaves in-flight entries alone.
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         p1_valid_q <= 1'b0;
         p1_port_q  <= 1'b0;
         p2_valid_q <= 1'b0;
         p2_port_q  <= 1'b0;
         victim0_q  <= 2'd0;
         victim1_q  <= 2'd0;
      end else begin
         p1_valid_q <= grant0 | grant1;
         p1_port_q  <= grant1;
         p2_valid_q <= p1_valid_q;
         p2_port_q  <= p1_port_q;
         if (rsp0_hit) victim0_q <= bus.lru_least_used_index;
         if (rsp1_hit) victim1_q <= bus.lru_least_used_index;
      end
   end

endmodule

// File: tb/tb_cache_lru_arbiter.sv
// Bench for cache_lru_arbiter: an LRU store stub with 2-cycle read-through latency, a
// reference model built from recency timestamps, a vector table and corner sequences.
module tb_cache_lru_arbiter;
   localparam int SetBits  = 9;
   localparam int NumSets  = 1 << SetBits;
   localparam int SweepLen = 4 * NumSets;

   logic main_clk   = 1'b0;
   logic main_rst_n = 1'b0;

   cache_lru_arbiter_if #(.SET_BITS(SetBits)) bus ();

   cache_lru_arbiter #(
      .SET_BITS      (SetBits),
      .INIT_ON_RESET (1'b1)
   ) dut (
      .main_clk   (main_clk),
      .main_rst_n (main_rst_n),
      .bus        (bus)
   );

   always #5 main_clk = ~main_clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // LRU store stub: each write stamps the way with a rising time; victim = oldest stamp.
   int         st_stamp [NumSets][4];
   int         st_time = 0;
   logic [1:0] st_p1, st_p2;
   assign bus.lru_least_used_index = st_p2;

   always @(posedge main_clk) begin
      int a;
      int b;
      a = int'(bus.lru_addr);
      b = 0;
      for (int i = 1; i < 4; i++) if (st_stamp[a][i] < st_stamp[a][b]) b = i;
      st_p1 <= 2'(b);
      st_p2 <= st_p1;
      if (bus.lru_enable_write) begin
         st_stamp[a][bus.lru_used_index] <= st_time + 1;
         st_time <= st_time + 1;
      end
   end

   // Reference model: recency per set, sweep position, pointer, expected response queue.
   typedef struct { int due; int port; int vic; } rsp_t;
   rsp_t rq[$];
   int   ref_stamp [NumSets][4];
   int   ref_time = 0;
   int   init_cnt = SweepLen;
   bit   exp_ptr  = 1'b0;
   int   last_vic [2] = '{0, 0};

   function automatic void ref_touch(input int s, input int w);
      ref_time++;
      ref_stamp[s][w] = ref_time;
   endfunction

   function automatic int ref_victim(input int s);
      int b = 0;
      for (int i = 1; i < 4; i++) if (ref_stamp[s][i] < ref_stamp[s][b]) b = i;
      return b;
   endfunction

   // Per-cycle check of every output, then advance the model by one clock.
   always @(negedge main_clk) begin
      int win, e_we, e_addr, e_used, idx, e_rv0, e_rv1;
      bit was_init, v0, v1;
      if (!main_rst_n) begin
         init_cnt = SweepLen;
         exp_ptr  = 1'b0;
         rq.delete();
         last_vic[0] = 0;
         last_vic[1] = 0;
      end
      was_init = (init_cnt > 0);
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      win = -1;
      if (!was_init) begin
         if (v0 && v1) win = int'(exp_ptr);
         else if (v0) win = 0;
         else if (v1) win = 1;
      end
      e_we = 0; e_addr = 0; e_used = 0;
      if (was_init) begin
         idx    = SweepLen - init_cnt;
         e_we   = 1;
         e_addr = idx / 4;
         e_used = 3 - (idx % 4);
      end else if (win == 0) begin
         e_we = int'(bus.req0_touch); e_addr = int'(bus.req0_addr);
         e_used = int'(bus.req0_used_index);
      end else if (win == 1) begin
         e_we = int'(bus.req1_touch); e_addr = int'(bus.req1_addr);
         e_used = int'(bus.req1_used_index);
      end
      chk("ready0", int'(bus.req0_ready), int'(win == 0));
      chk("ready1", int'(bus.req1_ready), int'(win == 1));
      chk("busy", int'(bus.busy), int'(was_init));
      chk("lru_enable_write", int'(bus.lru_enable_write), e_we);
      chk("lru_addr", int'(bus.lru_addr), e_addr);
      chk("lru_used_index", int'(bus.lru_used_index), e_used);
      e_rv0 = 0; e_rv1 = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         if (rq[0].port == 0) e_rv0 = 1; else e_rv1 = 1;
         last_vic[rq[0].port] = rq[0].vic;
         void'(rq.pop_front());
      end
      chk("rsp0_valid", int'(bus.rsp0_valid), e_rv0);
      chk("rsp1_valid", int'(bus.rsp1_valid), e_rv1);
      chk("rsp0_victim", int'(bus.rsp0_victim), last_vic[0]);
      chk("rsp1_victim", int'(bus.rsp1_victim), last_vic[1]);
      if (win >= 0) begin
         rq.push_back('{cyc + 2, win, ref_victim(e_addr)});
         if (e_we != 0) ref_touch(e_addr, e_used);
         if (v0 && v1) exp_ptr = !exp_ptr;
      end
      if (main_rst_n) begin
         if (was_init) begin
            ref_touch(e_addr, e_used);
            init_cnt--;
         end else if (bus.flush_req) begin
            init_cnt = SweepLen;
         end
      end
      cyc++;
   end

   task automatic drive(input bit v0, input int a0, input bit t0, input int u0,
                        input bit v1, input int a1, input bit t1, input int u1);
      bus.req0_valid      = v0;
      bus.req0_addr       = a0[SetBits-1:0];
      bus.req0_touch      = t0;
      bus.req0_used_index = u0[1:0];
      bus.req1_valid      = v1;
      bus.req1_addr       = a1[SetBits-1:0];
      bus.req1_touch      = t1;
      bus.req1_used_index = u1[1:0];
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(negedge main_clk);
      @(posedge main_clk);
      #1;
   endtask

   // Count busy cycles until RUN, bounded; start is the number already seen high.
   task automatic wait_sweep(input string name, input int start);
      int n = start;
      bit done = 1'b0;
      for (int i = 0; i < SweepLen + 50 && !done; i++) begin
         @(negedge main_clk);
         if (!bus.busy) done = 1'b1;
         else n++;
         @(posedge main_clk);
         #1;
      end
      chk({name, "_timeout"}, int'(done), 1);
      chk({name, "_busy_cycles"}, n, SweepLen);
   endtask

   typedef struct {
      bit v0; int a0; bit t0; int u0;
      bit v1; int a1; bit t1; int u1;
      bit r0; bit r1; int port; int vic;
   } vec_t;

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3};  // lookup right after init
      tbl[1]  = '{1, 4, 1, 3, 0, 0, 0, 0, 1, 0, 0, 3};  // touch sequence on set 4
      tbl[2]  = '{1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2};
      tbl[3]  = '{1, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2};
      tbl[4]  = '{1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2};
      tbl[5]  = '{1, 7, 0, 0, 1, 9, 0, 0, 1, 0, 0, 3};  // contention alternates
      tbl[6]  = '{1, 7, 0, 0, 1, 9, 0, 0, 0, 1, 1, 3};
      tbl[7]  = '{1, 7, 0, 0, 1, 9, 0, 0, 1, 0, 0, 3};
      tbl[8]  = '{1, 7, 0, 0, 1, 9, 0, 0, 0, 1, 1, 3};
      tbl[9]  = '{0, 0, 0, 0, 1, 9, 1, 2, 0, 1, 1, 3};  // lone port 1, pointer kept
      tbl[10] = '{1, 9, 1, 0, 1, 7, 0, 0, 1, 0, 0, 3};

      idle();
      bus.flush_req = 1'b0;
      repeat (3) @(posedge main_clk);
      #1;
      main_rst_n = 1'b1;
      wait_sweep("init", 0);

      for (int k = 0; k < 13; k++) begin
         if (k < 11) drive(tbl[k].v0, tbl[k].a0, tbl[k].t0, tbl[k].u0,
                           tbl[k].v1, tbl[k].a1, tbl[k].t1, tbl[k].u1);
         else idle();
         @(negedge main_clk);
         if (k < 11) begin
            chk($sformatf("tbl%0d_ready0", k), int'(bus.req0_ready), int'(tbl[k].r0));
            chk($sformatf("tbl%0d_ready1", k), int'(bus.req1_ready), int'(tbl[k].r1));
         end
         if (k >= 2) begin
            if (tbl[k-2].port == 0) begin
               chk($sformatf("tbl%0d_rsp0_valid", k - 2), int'(bus.rsp0_valid), 1);
               chk($sformatf("tbl%0d_rsp0_victim", k - 2), int'(bus.rsp0_victim),
                   tbl[k-2].vic);
            end else begin
               chk($sformatf("tbl%0d_rsp1_valid", k - 2), int'(bus.rsp1_valid), 1);
               chk($sformatf("tbl%0d_rsp1_victim", k - 2), int'(bus.rsp1_victim),
                   tbl[k-2].vic);
            end
         end
         @(posedge main_clk);
         #1;
      end

      // Random traffic, biased toward a few sets so same-set back-to-back happens.
      for (int i = 0; i < 500; i++) begin
         drive(($urandom % 4) != 0,
               ($urandom % 2) ? int'($urandom % 8) : int'($urandom % NumSets),
               $urandom % 2, int'($urandom % 4),
               ($urandom % 4) != 0,
               ($urandom % 2) ? int'($urandom % 8) : int'($urandom % NumSets),
               $urandom % 2, int'($urandom % 4));
         tick();
      end

      // Flush with accesses in flight; a flush pulse during INIT must be ignored.
      drive(1, 10, 1, 2, 0, 0, 0, 0);
      tick();
      drive(1, 12, 0, 0, 1, 11, 0, 0);
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      drive(1, 13, 0, 0, 0, 0, 0, 0);
      @(negedge main_clk);
      chk("flush_ready0_low", int'(bus.req0_ready), 0);
      chk("flush_busy_high", int'(bus.busy), 1);
      @(posedge main_clk);
      #1;
      idle();
      repeat (3) tick();
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      wait_sweep("flush", 5);
      drive(1, 10, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      @(negedge main_clk);
      chk("post_flush_rsp0_valid", int'(bus.rsp0_valid), 1);
      chk("post_flush_rsp0_victim", int'(bus.rsp0_victim), 3);
      @(posedge main_clk);
      #1;

      // Reset one cycle after an acceptance: its response must never appear.
      drive(1, 20, 1, 1, 0, 0, 0, 0);
      tick();
      idle();
      main_rst_n = 1'b0;
      repeat (3) tick();
      main_rst_n = 1'b1;
      @(negedge main_clk);
      chk("rst_sweep_addr", int'(bus.lru_addr), 0);
      chk("rst_sweep_used", int'(bus.lru_used_index), 3);
      chk("rst_sweep_we", int'(bus.lru_enable_write), 1);
      chk("rst_rsp0_victim", int'(bus.rsp0_victim), 0);
      @(posedge main_clk);
      #1;
      wait_sweep("reset", 1);

      for (int i = 0; i < 40; i++) begin
         drive($urandom % 2, int'($urandom % NumSets), $urandom % 2, int'($urandom % 4),
               $urandom % 2, int'($urandom % NumSets), $urandom % 2, int'($urandom % 4));
         tick();
      end
      idle();
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
